mem_stage_lsu: RTL and testbench

Memory-stage load/store unit of the five-stage MIPS pipeline, sitting directly downstream of the EX/MEM pipeline register and consuming its M-stage outputs. It checks address alignment, drives the SRAM-like data bus with a request/address-ok/data-ok handshake, stalls the pipeline while an access is outstanding, and returns the aligned, sign- or zero-extended load result toward the MEM/WB register. A flushed access that has already reached the bus is drained silently.

---
 rtl/mem_stage_lsu_pkg.sv | 27 ++
 rtl/mem_stage_lsu_align.sv | 97 +++++++++
 rtl/mem_stage_lsu.sv | 157 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit: load/store kind bit
// indices, bus size codes and the access FSM states.
package mem_stage_lsu_pkg;

  localparam int LS_LB  = 0;
  localparam int LS_LBU = 1;
  localparam int LS_LH  = 2;
  localparam int LS_LHU = 3;
  localparam int LS_LW  = 4;
  localparam int LS_SB  = 5;
  localparam int LS_SH  = 6;
  localparam int LS_SW  = 7;
  localparam int LS_LWL = 8;
  localparam int LS_LWR = 9;
  localparam int LS_SWL = 10;
  localparam int LS_SWR = 11;
  localparam int LS_LL  = 12;
  localparam int LS_SC  = 13;
  localparam int LS_W   = 14;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational load extraction/merge and store strobe/data generation.
// LWL/LWR/SWL/SWR are handled only when MEM_UNALIGNED_EN is defined.
module lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [13:0] l_s_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rt_value,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [1:0]  size,
  output logic        misalign,
  output logic        unsup
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = '0;
    if (l_s_type[LS_LB])                     load_data = {{24{byte_sel[7]}}, byte_sel};
    if (l_s_type[LS_LBU])                    load_data = {24'b0, byte_sel};
    if (l_s_type[LS_LH])                     load_data = {{16{half_sel[15]}}, half_sel};
    if (l_s_type[LS_LHU])                    load_data = {16'b0, half_sel};
    if (l_s_type[LS_LW] || l_s_type[LS_LL])  load_data = rdata;
`ifdef MEM_UNALIGNED_EN
    // Left/right loads merge the fetched bytes into the old register value.
    if (l_s_type[LS_LWL]) begin
      case (addr_lo)
        2'd0:    load_data = {rdata[7:0],  rt_value[23:0]};
        2'd1:    load_data = {rdata[15:0], rt_value[15:0]};
        2'd2:    load_data = {rdata[23:0], rt_value[7:0]};
        default: load_data = rdata;
      endcase
    end
    if (l_s_type[LS_LWR]) begin
      case (addr_lo)
        2'd0:    load_data = rdata;
        2'd1:    load_data = {rt_value[31:24], rdata[31:8]};
        2'd2:    load_data = {rt_value[31:16], rdata[31:16]};
        default: load_data = {rt_value[31:8],  rdata[31:24]};
      endcase
    end
`endif
  end

  always_comb begin
    wdata = rt_value;
    wstrb = 4'b0000;
    size  = SIZE_WORD;
    if (l_s_type[LS_LB] || l_s_type[LS_LBU] || l_s_type[LS_SB]) size = SIZE_BYTE;
    if (l_s_type[LS_LH] || l_s_type[LS_LHU] || l_s_type[LS_SH]) size = SIZE_HALF;
    if (l_s_type[LS_SB]) begin
      wdata = {4{rt_value[7:0]}};
      wstrb = 4'b0001 << addr_lo;
    end
    if (l_s_type[LS_SH]) begin
      wdata = {2{rt_value[15:0]}};
      wstrb = 4'b0011 << addr_lo;
    end
    if (l_s_type[LS_SW] || l_s_type[LS_SC]) wstrb = 4'b1111;
`ifdef MEM_UNALIGNED_EN
    if (l_s_type[LS_SWL]) begin
      case (addr_lo)
        2'd0:    begin wstrb = 4'b0001; wdata = {24'b0, rt_value[31:24]}; end
        2'd1:    begin wstrb = 4'b0011; wdata = {16'b0, rt_value[31:16]}; end
        2'd2:    begin wstrb = 4'b0111; wdata = {8'b0,  rt_value[31:8]};  end
        default: begin wstrb = 4'b1111; wdata = rt_value;                 end
      endcase
    end
    if (l_s_type[LS_SWR]) begin
      case (addr_lo)
        2'd0:    begin wstrb = 4'b1111; wdata = rt_value;                 end
        2'd1:    begin wstrb = 4'b1110; wdata = {rt_value[23:0], 8'b0};  end
        2'd2:    begin wstrb = 4'b1100; wdata = {rt_value[15:0], 16'b0}; end
        default: begin wstrb = 4'b1000; wdata = {rt_value[7:0],  24'b0}; end
      endcase
    end
`endif
  end

  assign misalign = ((l_s_type[LS_LW] | l_s_type[LS_LL] | l_s_type[LS_SW] | l_s_type[LS_SC])
                     & (addr_lo != 2'b00))
                  | ((l_s_type[LS_LH] | l_s_type[LS_LHU] | l_s_type[LS_SH]) & addr_lo[0]);

`ifdef MEM_UNALIGNED_EN
  assign unsup = 1'b0;
`else
  assign unsup = l_s_type[LS_LWL] | l_s_type[LS_LWR] | l_s_type[LS_SWL] | l_s_type[LS_SWR];
`endif

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: alignment check, request/addr_ok/data_ok bus FSM, stall and
// load return. Optional LWL/LWR/SWL/SWR support via MEM_UNALIGNED_EN.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_enM,
  input  logic        mem_write_enM,
  input  logic [13:0] l_s_typeM,
  input  logic [31:0] mem_addrM,
  input  logic [31:0] rt_valueM,
  input  logic        flushM,
  input  logic        stall_otherM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        stall_lsu,
  output logic [31:0] load_dataM,
  output logic        adelM,
  output logic        adesM,
  output logic [31:0] bad_vaddrM
);

  logic [31:0] ext_load, ext_wdata, bus_addr;
  logic [3:0]  ext_wstrb;
  logic [1:0]  ext_size;
  logic        misalign, unsup, access;

  lsu_state_e  state_q, state_d;
  logic        cancel_q, cancel_d;
  logic [31:0] latch_q, latch_d;
  logic [31:0] req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
  logic [3:0]  req_wstrb_q, req_wstrb_d;
  logic [1:0]  req_size_q, req_size_d;
  logic        req_wr_q, req_wr_d;

  lsu_align u_align (
    .l_s_type  (l_s_typeM),
    .addr_lo   (mem_addrM[1:0]),
    .rt_value  (rt_valueM),
    .rdata     (data_rdata),
    .load_data (ext_load),
    .wdata     (ext_wdata),
    .wstrb     (ext_wstrb),
    .size      (ext_size),
    .misalign  (misalign),
    .unsup     (unsup)
  );

  assign adelM      = mem_read_enM & misalign;
  assign adesM      = mem_write_enM & misalign;
  assign bad_vaddrM = mem_addrM;
  assign access     = (mem_read_enM | mem_write_enM) & ~flushM & ~adelM & ~adesM & ~unsup;
  assign bus_addr   = (ext_size == SIZE_WORD) ? {mem_addrM[31:2], 2'b00} : mem_addrM;

  always_comb begin
    state_d     = state_q;
    cancel_d    = cancel_q;
    latch_d     = latch_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    req_size_d  = req_size_q;
    req_wr_d    = req_wr_q;
    data_req    = 1'b0;
    data_wr     = mem_write_enM;
    data_size   = ext_size;
    data_addr   = bus_addr;
    data_wdata  = ext_wdata;
    data_wstrb  = ext_wstrb;
    stall_lsu   = 1'b0;
    load_dataM  = '0;
    case (state_q)
      IDLE: begin
        if (access) begin
          data_req    = 1'b1;
          stall_lsu   = 1'b1;
          req_addr_d  = bus_addr;
          req_wdata_d = ext_wdata;
          req_wstrb_d = ext_wstrb;
          req_size_d  = ext_size;
          req_wr_d    = mem_write_enM;
          state_d     = data_addr_ok ? WAIT : REQ;
        end
      end
      REQ: begin
        // A raised request is never withdrawn, so it replays the captured
        // fields even if the M-stage inputs change under a flush.
        data_req   = 1'b1;
        stall_lsu  = 1'b1;
        data_wr    = req_wr_q;
        data_size  = req_size_q;
        data_addr  = req_addr_q;
        data_wdata = req_wdata_q;
        data_wstrb = req_wstrb_q;
        if (flushM) cancel_d = 1'b1;
        if (data_addr_ok) begin
          state_d  = (cancel_q | flushM) ? DRAIN : WAIT;
          cancel_d = 1'b0;
        end
      end
      WAIT: begin
        if (data_data_ok) begin
          load_dataM = ext_load;
          if (stall_otherM && !flushM) begin
            latch_d = ext_load;
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          stall_lsu = 1'b1;
          if (flushM) state_d = DRAIN;
        end
      end
      DONE: begin
        load_dataM = latch_q;
        if (flushM || !stall_otherM) state_d = IDLE;
      end
      DRAIN: begin
        stall_lsu = access;
        if (data_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cancel_q    <= 1'b0;
      latch_q     <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      req_size_q  <= SIZE_BYTE;
      req_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cancel_q    <= cancel_d;
      latch_q     <= latch_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      req_size_q  <= req_size_d;
      req_wr_q    <= req_wr_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: table of single accesses with a load
// scoreboard, plus hand-written flush, hold, reset and unsupported-op sequences.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_enM, mem_write_enM, flushM, stall_otherM;
  logic [13:0] l_s_typeM;
  logic [31:0] mem_addrM, rt_valueM;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic        stall_lsu, adelM, adesM;
  logic [31:0] load_dataM, bad_vaddrM;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic [13:0] kind;
    logic        rd, wr;
    logic [31:0] addr, rt, rdata;
    logic        addr_lat;
    int          gap;
    logic [31:0] exp_load, exp_daddr, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [1:0]  exp_size;
    logic        exp_adel, exp_ades;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];

  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .mem_read_enM(mem_read_enM), .mem_write_enM(mem_write_enM),
    .l_s_typeM(l_s_typeM), .mem_addrM(mem_addrM), .rt_valueM(rt_valueM),
    .flushM(flushM), .stall_otherM(stall_otherM),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .stall_lsu(stall_lsu), .load_dataM(load_dataM),
    .adelM(adelM), .adesM(adesM), .bad_vaddrM(bad_vaddrM)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [13:0] kindBit(input int idx);
    logic [13:0] one;
    one = 14'd1;
    return one << idx;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    mem_read_enM = 1'b0; mem_write_enM = 1'b0; l_s_typeM = '0;
    mem_addrM = '0; rt_valueM = '0; flushM = 1'b0; stall_otherM = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
  endtask

  task automatic addVec(input string name, input int kidx, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] rt, input logic [31:0] rdata,
                        input logic addr_lat, input int gap, input logic [31:0] exp_load,
                        input logic [31:0] exp_daddr, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_wstrb, input logic [1:0] exp_size,
                        input logic exp_adel, input logic exp_ades);
    vec_t v;
    v.name = name; v.kind = kindBit(kidx); v.rd = rd; v.wr = wr;
    v.addr = addr; v.rt = rt; v.rdata = rdata; v.addr_lat = addr_lat; v.gap = gap;
    v.exp_load = exp_load; v.exp_daddr = exp_daddr; v.exp_wdata = exp_wdata;
    v.exp_wstrb = exp_wstrb; v.exp_size = exp_size;
    v.exp_adel = exp_adel; v.exp_ades = exp_ades;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] exp;
    idleInputs();
    mem_read_enM = v.rd; mem_write_enM = v.wr; l_s_typeM = v.kind;
    mem_addrM = v.addr; rt_valueM = v.rt;
    if (v.exp_adel || v.exp_ades) begin
      #2;
      checkOutput({v.name, "_adel"}, 32'(adelM), 32'(v.exp_adel));
      checkOutput({v.name, "_ades"}, 32'(adesM), 32'(v.exp_ades));
      checkOutput({v.name, "_badva"}, bad_vaddrM, v.addr);
      checkOutput({v.name, "_noreq"}, 32'(data_req), 32'd0);
      checkOutput({v.name, "_nostall"}, 32'(stall_lsu), 32'd0);
      step();
      checkOutput({v.name, "_noreq2"}, 32'(data_req), 32'd0);
      idleInputs();
      return;
    end
    data_addr_ok = !v.addr_lat;
    #2;
    checkOutput({v.name, "_req"}, 32'(data_req), 32'd1);
    checkOutput({v.name, "_stall"}, 32'(stall_lsu), 32'd1);
    checkOutput({v.name, "_addr"}, data_addr, v.exp_daddr);
    checkOutput({v.name, "_size"}, 32'(data_size), 32'(v.exp_size));
    checkOutput({v.name, "_wr"}, 32'(data_wr), 32'(v.wr));
    if (v.wr) begin
      checkOutput({v.name, "_wdata"}, data_wdata, v.exp_wdata);
      checkOutput({v.name, "_wstrb"}, 32'(data_wstrb), 32'(v.exp_wstrb));
    end
    step();
    if (v.addr_lat) begin
      data_addr_ok = 1'b1;
      #2;
      checkOutput({v.name, "_req_held"}, 32'(data_req), 32'd1);
      checkOutput({v.name, "_addr_held"}, data_addr, v.exp_daddr);
      step();
    end
    if (v.rd) sb.push_back(v.exp_load);
    data_addr_ok = 1'b0;
    for (int g = 0; g < v.gap; g++) begin
      #2;
      checkOutput({v.name, "_wait_stall"}, 32'(stall_lsu), 32'd1);
      checkOutput({v.name, "_wait_noreq"}, 32'(data_req), 32'd0);
      step();
    end
    data_data_ok = 1'b1;
    data_rdata = v.rdata;
    #2;
    checkOutput({v.name, "_ok_stall"}, 32'(stall_lsu), 32'd0);
    if (v.rd) begin
      exp = sb.pop_front();
      checkOutput({v.name, "_load"}, load_dataM, exp);
    end
    step();
    idleInputs();
  endtask

  initial begin
    idleInputs();
    rst = 1'b0;

    //      name       kind    rd wr addr          rt            rdata        lat gap load          daddr         wdata         strb  sz adel ades
    addVec("lw",      LS_LW,  1, 0, 32'h80000004, 32'h0,        32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 32'h80000004, 32'h0,        4'h0, 2, 0, 0);
    addVec("lb_neg",  LS_LB,  1, 0, 32'h80000003, 32'h0,        32'h80000000, 1, 0, 32'hFFFFFF80, 32'h80000003, 32'h0,        4'h0, 0, 0, 0);
    addVec("lbu",     LS_LBU, 1, 0, 32'h80000003, 32'h0,        32'h80000000, 0, 0, 32'h00000080, 32'h80000003, 32'h0,        4'h0, 0, 0, 0);
    addVec("lh_neg",  LS_LH,  1, 0, 32'h80000002, 32'h0,        32'h80011234, 0, 2, 32'hFFFF8001, 32'h80000002, 32'h0,        4'h0, 1, 0, 0);
    addVec("lhu",     LS_LHU, 1, 0, 32'h80000000, 32'h0,        32'h8001F234, 1, 1, 32'h0000F234, 32'h80000000, 32'h0,        4'h0, 1, 0, 0);
    addVec("lb_pos",  LS_LB,  1, 0, 32'h80000001, 32'h0,        32'h00007F00, 0, 0, 32'h0000007F, 32'h80000001, 32'h0,        4'h0, 0, 0, 0);
    addVec("ll",      LS_LL,  1, 0, 32'h80000008, 32'h0,        32'h01234567, 0, 0, 32'h01234567, 32'h80000008, 32'h0,        4'h0, 2, 0, 0);
    addVec("sh",      LS_SH,  0, 1, 32'h80000002, 32'h1234ABCD, 32'h0,        0, 0, 32'h0,        32'h80000002, 32'hABCDABCD, 4'hC, 1, 0, 0);
    addVec("sb",      LS_SB,  0, 1, 32'h80000001, 32'h000000A5, 32'h0,        1, 0, 32'h0,        32'h80000001, 32'hA5A5A5A5, 4'h2, 0, 0, 0);
    addVec("sw",      LS_SW,  0, 1, 32'h80000008, 32'hCAFEF00D, 32'h0,        0, 1, 32'h0,        32'h80000008, 32'hCAFEF00D, 4'hF, 2, 0, 0);
    addVec("lw_mis",  LS_LW,  1, 0, 32'h80000002, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        4'h0, 2, 1, 0);
    addVec("sw_mis",  LS_SW,  0, 1, 32'h80000001, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        4'h0, 2, 0, 1);
    addVec("lh_mis",  LS_LH,  1, 0, 32'h80000001, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        4'h0, 1, 1, 0);
    addVec("sh_mis",  LS_SH,  0, 1, 32'h80000003, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        4'h0, 1, 0, 1);

    step(); step();
    #2;
    checkOutput("rst_req", 32'(data_req), 32'd0);
    checkOutput("rst_stall", 32'(stall_lsu), 32'd0);
    checkOutput("rst_load", load_dataM, 32'd0);
    checkOutput("rst_adel", 32'(adelM), 32'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Flush while waiting for data: drained silently, then next LW issues.
    mem_read_enM = 1'b1; l_s_typeM = kindBit(LS_LW); mem_addrM = 32'h80000010;
    data_addr_ok = 1'b1;
    #2; checkOutput("fw_req", 32'(data_req), 32'd1);
    step();
    data_addr_ok = 1'b0; flushM = 1'b1;
    #2; checkOutput("fw_wait_stall", 32'(stall_lsu), 32'd1);
    step();
    flushM = 1'b0; mem_addrM = 32'h80000020;
    #2;
    checkOutput("fw_drain_noreq", 32'(data_req), 32'd0);
    checkOutput("fw_drain_stall", 32'(stall_lsu), 32'd1);
    step();
    data_data_ok = 1'b1; data_rdata = 32'h11111111;
    #2;
    checkOutput("fw_drain_load", load_dataM, 32'd0);
    checkOutput("fw_drain_ok_noreq", 32'(data_req), 32'd0);
    checkOutput("fw_drain_ok_stall", 32'(stall_lsu), 32'd1);
    step();
    data_data_ok = 1'b0;
    #2;
    checkOutput("fw_next_req", 32'(data_req), 32'd1);
    checkOutput("fw_next_addr", data_addr, 32'h80000020);
    data_addr_ok = 1'b1;
    step();
    sb.push_back(32'h22223333);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h22223333;
    #2;
    checkOutput("fw_next_load", load_dataM, sb.pop_front());
    checkOutput("fw_next_stall", 32'(stall_lsu), 32'd0);
    step();
    idleInputs();

    // Data returns while another stage holds M: result held, no re-request.
    mem_read_enM = 1'b1; l_s_typeM = kindBit(LS_LW); mem_addrM = 32'h80000030;
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h55AA33CC; stall_otherM = 1'b1;
    #2;
    checkOutput("hold_bypass", load_dataM, 32'h55AA33CC);
    checkOutput("hold_ok_stall", 32'(stall_lsu), 32'd0);
    step();
    data_data_ok = 1'b0; data_rdata = 32'hFFFFFFFF;
    for (int c = 0; c < 3; c++) begin
      #2;
      checkOutput("hold_load", load_dataM, 32'h55AA33CC);
      checkOutput("hold_noreq", 32'(data_req), 32'd0);
      checkOutput("hold_nostall", 32'(stall_lsu), 32'd0);
      step();
    end
    stall_otherM = 1'b0;
    #2;
    checkOutput("hold_release_load", load_dataM, 32'h55AA33CC);
    checkOutput("hold_release_noreq", 32'(data_req), 32'd0);
    step();
    idleInputs();

    // Flush while the request is still pending: held stable, then drained.
    mem_read_enM = 1'b1; l_s_typeM = kindBit(LS_LW); mem_addrM = 32'h80000044;
    #2; checkOutput("fr_req", 32'(data_req), 32'd1);
    step();
    flushM = 1'b1; mem_read_enM = 1'b0; l_s_typeM = '0; mem_addrM = 32'h0;
    #2;
    checkOutput("fr_req_held", 32'(data_req), 32'd1);
    checkOutput("fr_addr_held", data_addr, 32'h80000044);
    checkOutput("fr_size_held", 32'(data_size), 32'(SIZE_WORD));
    step();
    flushM = 1'b0; data_addr_ok = 1'b1;
    #2;
    checkOutput("fr_req_held2", 32'(data_req), 32'd1);
    checkOutput("fr_addr_held2", data_addr, 32'h80000044);
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h99999999;
    #2;
    checkOutput("fr_drain_load", load_dataM, 32'd0);
    checkOutput("fr_drain_stall", 32'(stall_lsu), 32'd0);
    step();
    data_data_ok = 1'b0;
    #2; checkOutput("fr_after_noreq", 32'(data_req), 32'd0);
    step();
    idleInputs();

    // Unaligned-word op in the default build: no request, zero result.
    mem_read_enM = 1'b1; l_s_typeM = kindBit(LS_LWL); mem_addrM = 32'h80000001;
    rt_valueM = 32'hAABBCCDD; data_rdata = 32'h12345678;
    #2;
    checkOutput("lwl_noreq", 32'(data_req), 32'd0);
    checkOutput("lwl_load", load_dataM, 32'd0);
    checkOutput("lwl_adel", 32'(adelM), 32'd0);
    checkOutput("lwl_stall", 32'(stall_lsu), 32'd0);
    step();
    idleInputs();

    // Reset during an outstanding access abandons it.
    mem_read_enM = 1'b1; l_s_typeM = kindBit(LS_LW); mem_addrM = 32'h80000050;
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    #2; checkOutput("rstmid_wait_stall", 32'(stall_lsu), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    idleInputs();
    #2;
    checkOutput("rstmid_stall", 32'(stall_lsu), 32'd0);
    checkOutput("rstmid_req", 32'(data_req), 32'd0);
    step();

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
